// File: rtl/serial_tx.sv
// -----------------------------------------------------------------------------
// serial_tx - framed parallel-in / serial-out transmitter.
//
// Accepts one DATA_WIDTH-bit word through a valid/ready handshake. It then
// drives it onto a single line as: start bit (0), data bits LSB first, and
// stop bit (1). Each bit is held for CLKS_PER_BIT cycles. The line idles high.
//
// Ports:
//   i_clk    system clock, rising edge
//   i_rst    synchronous active-high reset (aborts any frame in flight)
//   i_data   word to send, captured only on the accepting edge
//   i_valid  producer has a word on i_data
//   o_ready  high only in IDLE; a word is taken when i_valid && o_ready
//   o_tx     serial line output, registered-state driven
//   o_busy   high for the whole frame (START/DATA/STOP)
//   o_done   single-cycle pulse in the first IDLE cycle after the stop bit
// -----------------------------------------------------------------------------
module serial_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_valid,
    output logic                  o_ready,
    output logic                  o_tx,
    output logic                  o_busy,
    output logic                  o_done
);

    // Both counters are at least 1 bit wide. This keeps the degenerate
    // parameter values (DATA_WIDTH=1, CLKS_PER_BIT=1) legal.
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (DATA_WIDTH   > 1) ? $clog2(DATA_WIDTH)   : 1;

    localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CYC_ONE  = CW'(1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);
    localparam logic [BW-1:0] BIT_ONE  = BW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t                state_q,   state_d;
    logic [DATA_WIDTH-1:0] shreg_q,   shreg_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [CW-1:0]         cyc_cnt_q, cyc_cnt_d;
    logic                  done_q,    done_d;

    // Last cycle of the current bit period. With CLKS_PER_BIT=1 this is
    // always true, so every state advances on each edge.
    logic bit_end;
    assign bit_end = (cyc_cnt_q == CYC_LAST);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            cyc_cnt_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            cyc_cnt_q <= cyc_cnt_d;
            done_q    <= done_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        cyc_cnt_d = cyc_cnt_q;
        done_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                cyc_cnt_d = '0;
                bit_cnt_d = '0;
                // o_ready is high throughout IDLE, so i_valid alone accepts.
                if (i_valid) begin
                    shreg_d = i_data;
                    state_d = START;
                end
            end

            START: begin
                if (bit_end) begin
                    cyc_cnt_d = '0;
                    state_d   = DATA;
                end else begin
                    cyc_cnt_d = cyc_cnt_q + CYC_ONE;
                end
            end

            DATA: begin
                if (bit_end) begin
                    cyc_cnt_d = '0;
                    shreg_d   = shreg_q >> 1;
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_ONE;
                    end
                end else begin
                    cyc_cnt_d = cyc_cnt_q + CYC_ONE;
                end
            end

            STOP: begin
                if (bit_end) begin
                    cyc_cnt_d = '0;
                    state_d   = IDLE;
                    done_d    = 1'b1;
                end else begin
                    cyc_cnt_d = cyc_cnt_q + CYC_ONE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs: decoded from registered state only
    // ------------------------------------------------------------------
    assign o_ready = (state_q == IDLE);
    assign o_busy  = (state_q != IDLE);
    assign o_done  = done_q;

    always_comb begin
        o_tx = 1'b1;
        unique case (state_q)
            IDLE:    o_tx = 1'b1;
            START:   o_tx = 1'b0;
            DATA:    o_tx = shreg_q[0];
            STOP:    o_tx = 1'b1;
            default: o_tx = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_serial_tx.sv
// -----------------------------------------------------------------------------
// tb_serial_tx - scoreboard bench for serial_tx.
// DUT 0 uses CLKS_PER_BIT=4 and DUT 1 uses CLKS_PER_BIT=1, both with DATA_WIDTH=8.
// Stimulus pushes each accepted word into a per-DUT queue. A monitor decodes
// the line against an ideal frame (start, LSB-first data, stop) and checks
// timing, handshake and done behaviour cycle by cycle.
// -----------------------------------------------------------------------------
module tb_serial_tx;

    logic       clk = 1'b0;
    logic [1:0] rst, valid, tx, ready, busy, done;
    logic [7:0] data [2];

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] d;
        int         t;   // edge number on which the word was accepted
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4)) u_dut0 (
        .i_clk(clk), .i_rst(rst[0]), .i_data(data[0]), .i_valid(valid[0]),
        .o_ready(ready[0]), .o_tx(tx[0]), .o_busy(busy[0]), .o_done(done[0])
    );

    serial_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(1)) u_dut1 (
        .i_clk(clk), .i_rst(rst[1]), .i_data(data[1]), .i_valid(valid[1]),
        .o_ready(ready[1]), .o_tx(tx[1]), .o_busy(busy[1]), .o_done(done[1])
    );

    task automatic chk(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s dut%0d cyc=%0d actual=%h required=%h", name, k, cyc, act, req);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor: ideal-frame reference, evaluated away from the active edge
    // ------------------------------------------------------------------
    bit         in_frame [2];
    bit         acc_pend [2];
    bit         rst_pend [2];
    bit         mon_on   [2];
    int         fcyc     [2];
    logic [7:0] cur      [2];

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            int         c, len, b;
            logic       exp_tx;
            logic [7:0] w;
            exp_t       e;
            c   = (k == 0) ? 4 : 1;
            len = 10 * c;
            if (rst_pend[k]) begin
                chk("reset_outs", k, {28'd0, tx[k], ready[k], busy[k], done[k]}, 32'hC);
                in_frame[k] = 1'b0;
                mon_on[k]   = 1'b1;
            end else if (mon_on[k]) begin
                if (!in_frame[k] && acc_pend[k]) begin
                    if ((k == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
                        chk("unexpected_frame", k, 32'd1, 32'd0);
                        cur[k] = 8'h00;
                    end else begin
                        e = (k == 0) ? q0.pop_front() : q1.pop_front();
                        chk("start_cycle", k, cyc, e.t);
                        cur[k] = e.d;
                    end
                    in_frame[k] = 1'b1;
                    fcyc[k]     = 0;
                end
                if (in_frame[k] && fcyc[k] < len) begin
                    b = fcyc[k] / c;
                    w = cur[k];
                    if (b == 0)      exp_tx = 1'b0;
                    else if (b <= 8) exp_tx = w[b-1];
                    else             exp_tx = 1'b1;
                    chk("frame_ctl", k, {29'd0, ready[k], busy[k], done[k]}, 32'h2);
                    chk("tx_bit", k, {31'd0, tx[k]}, {31'd0, exp_tx});
                    fcyc[k]++;
                end else if (in_frame[k]) begin
                    chk("done_cycle", k, {28'd0, tx[k], ready[k], busy[k], done[k]}, 32'hD);
                    in_frame[k] = 1'b0;
                end else begin
                    chk("idle", k, {28'd0, tx[k], ready[k], busy[k], done[k]}, 32'hC);
                end
            end
            acc_pend[k] = mon_on[k] && !in_frame[k] && valid[k] && !rst[k];
            rst_pend[k] = rst[k];
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (inputs change 1 time unit after the rising edge)
    // ------------------------------------------------------------------
    task automatic send(input int k, input logic [7:0] d);
        int   n;
        exp_t e;
        n = 0;
        @(posedge clk); #1;
        valid[k] = 1'b1;
        data[k]  = d;
        while (!ready[k]) begin
            @(posedge clk); #1;
            n++;
            if (n > 500) begin
                chk("ready_timeout", k, 32'd1, 32'd0);
                break;
            end
        end
        e.d = d;
        e.t = cyc + 1;
        if (k == 0) q0.push_back(e); else q1.push_back(e);
        @(posedge clk); #1;
        valid[k] = 1'b0;
        data[k]  = 8'($urandom);
    endtask

    task automatic noise(input int k, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            valid[k] = 1'b1;
            data[k]  = 8'h3C;
        end
        @(posedge clk); #1;
        valid[k] = 1'b0;
    endtask

    task automatic wait_idle(input int k);
        int n;
        n = 0;
        while (!ready[k]) begin
            @(posedge clk); #1;
            n++;
            if (n > 500) begin
                chk("idle_timeout", k, 32'd1, 32'd0);
                break;
            end
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic pulse_rst(input int k);
        rst[k] = 1'b1;
        @(posedge clk); #1;
        rst[k] = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int k, len, r;
        rst     = 2'b11;
        valid   = 2'b11;
        data[0] = 8'hFF;
        data[1] = 8'hFF;
        repeat (2) @(posedge clk);
        #1;
        rst   = 2'b00;
        valid = 2'b00;
        repeat (3) @(posedge clk);
        #1;

        // Single frame
        send(0, 8'hA5);
        wait_idle(0);

        // Back-to-back: the second word is held until the done cycle
        send(0, 8'h00);
        send(0, 8'hFF);
        wait_idle(0);

        // Valid while busy is ignored
        send(0, 8'hA5);
        noise(0, 5);
        wait_idle(0);
        repeat (5) @(posedge clk);
        #1;

        // Reset during data bit 3, then a full frame
        send(0, 8'h0F);
        repeat (17) @(posedge clk);
        #1;
        pulse_rst(0);
        repeat (2) @(posedge clk);
        #1;
        send(0, 8'h5A);
        wait_idle(0);

        // One clock per bit
        send(1, 8'h81);
        wait_idle(1);

        // Randomized traffic
        for (int i = 0; i < 24; i++) begin
            k   = int'($urandom_range(0, 1));
            len = (k == 0) ? 40 : 10;
            send(k, 8'($urandom));
            case ($urandom_range(0, 5))
                0: noise(k, int'($urandom_range(1, 5)));
                1: begin
                    r = int'($urandom_range(1, len - 3));
                    repeat (r) @(posedge clk);
                    #1;
                    pulse_rst(k);
                end
                default: ;
            endcase
            r = int'($urandom_range(0, 3));
            if (r != 0) begin
                wait_idle(k);
                repeat (r) @(posedge clk);
                #1;
            end
        end

        wait_idle(0);
        wait_idle(1);
        chk("queue_empty", 0, q0.size(), 32'd0);
        chk("queue_empty", 1, q1.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
